// File: rtl/pulse_int_pkg.sv
// Shared definitions for the pulse-integration sequencer.
//   - state encoding for the sequencer FSM
//   - default index width and the runtime configuration struct
//   - cfg_valid(): legality check applied whenever a config is taken
package pulse_int_pkg;

  localparam int IDX_W_DEF = 16;

  // Sequencer states (plain constants so legacy code can match on the codes)
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_ARMED   = 2'd1;
  localparam state_t ST_CAPTURE = 2'd2;
  localparam state_t ST_GAP     = 2'd3;

  // Field widths follow IDX_W_DEF; instances must keep IDX_W equal to it.
  typedef struct packed {
    logic [IDX_W_DEF-1:0] n_pulses;
    logic [IDX_W_DEF-1:0] n_samples;
    logic [IDX_W_DEF-1:0] start_idx;
    logic [IDX_W_DEF-1:0] end_idx;
  } cfg_t;

  // At least one pulse and one sample, and a non-empty window inside the pulse.
  function automatic logic cfg_valid(input cfg_t c);
    return (c.n_pulses != '0) && (c.n_samples != '0) &&
           (c.start_idx <= c.end_idx) && (c.end_idx < c.n_samples);
  endfunction

endpackage

// File: rtl/pulse_int_sched_if.sv
// Accumulator-FIFO strobe bundle driven by the sequencer.
//   acc_wr_en  : write summed/raw sample into the accumulator FIFO
//   acc_rd_en  : pop the previous partial sum
//   acc_bypass : first pulse of frame, write raw sample without adding
//   out_valid  : final-pulse sample inside the window, emit the sum
// master = sequencer side, slave = accumulator/datapath side.
interface pulse_int_sched_if;
  logic acc_wr_en;
  logic acc_rd_en;
  logic acc_bypass;
  logic out_valid;

  modport master (output acc_wr_en, acc_rd_en, acc_bypass, out_valid);
  modport slave  (input  acc_wr_en, acc_rd_en, acc_bypass, out_valid);
endinterface

// File: rtl/pulse_int_cfg_shadow.sv
// Configuration shadow for the pulse-integration sequencer.
// Holds the active config, latches update requests until a frame boundary,
// validates every config before it is taken, and keeps the sticky err_cfg.
// Ports:
//   aclk, aresetn : clock, synchronous active-low reset
//   cfg_in        : live configuration inputs
//   cfg_update    : strobe, request that cfg_in be taken at next boundary
//   idle_req      : sequencer leaving IDLE this cycle (load unconditionally)
//   frame_end     : last sample of a frame accepted this cycle
//   shadow        : active configuration
//   in_ok         : cfg_in is currently legal
//   err_cfg       : sticky, a config was rejected
//   err_clr       : a legal cfg_update arrived; clears sticky errors
module pulse_int_cfg_shadow
  import pulse_int_pkg::*;
(
  input  logic aclk,
  input  logic aresetn,
  input  cfg_t cfg_in,
  input  logic cfg_update,
  input  logic idle_req,
  input  logic frame_end,
  output cfg_t shadow,
  output logic in_ok,
  output logic err_cfg,
  output logic err_clr
);

  logic update_pending;
  logic take_idle;
  logic take_frame;
  logic reject;

  assign in_ok      = cfg_valid(cfg_in);
  assign err_clr    = cfg_update & in_ok;
  assign take_idle  = idle_req;
  assign take_frame = frame_end & update_pending;
  // A bad config at IDLE exit keeps the sequencer in IDLE; at a frame
  // boundary the old shadow stays in force.
  assign reject     = (take_idle | take_frame) & ~in_ok;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      shadow         <= '0;
      update_pending <= 1'b0;
      err_cfg        <= 1'b0;
    end else begin
      if ((take_idle | take_frame) && in_ok)
        shadow <= cfg_in;

      // A fresh request wins over consumption in the same cycle.
      if (cfg_update)
        update_pending <= 1'b1;
      else if (take_frame || (take_idle && in_ok))
        update_pending <= 1'b0;

      if (reject)
        err_cfg <= 1'b1;
      else if (err_clr)
        err_cfg <= 1'b0;
    end
  end

endmodule

// File: rtl/pulse_int_sched.sv
// Pulse-integration sequencer. Aligns the ADC sample stream to the pulse
// trigger, counts samples per pulse and pulses per frame, and drives the
// accumulator FIFO strobes with zero latency to the sample.
// Ports:
//   aclk, aresetn      : clock, synchronous active-low reset
//   enable             : run request (level); dropping it finishes the frame
//   abort              : strobe, discard current frame and return to IDLE
//   trigger            : pulse-start marker, rising edge used
//   s_axis_tvalid      : ADC sample valid (always accepted)
//   cfg_*              : runtime configuration, taken via the shadow
//   cfg_update         : strobe, request new configuration
//   acc                : accumulator strobe bundle (master)
//   sample_idx         : index of next sample within the pulse
//   pulse_idx          : index of current pulse within the frame
//   frame_done         : one-cycle pulse after the last sample of a frame
//   frame_count        : completed frames, wraps
//   busy               : sequencer not IDLE
//   err_late_trig      : sticky, trigger edge seen during CAPTURE
//   err_cfg            : sticky, a configuration was rejected
// With n_pulses==1 there is no read-back, so out_valid never asserts.
module pulse_int_sched
  import pulse_int_pkg::*;
#(
  parameter int IDX_W       = IDX_W_DEF,
  parameter int FRAME_CNT_W = 32
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic                   enable,
  input  logic                   abort,
  input  logic                   trigger,
  input  logic                   s_axis_tvalid,
  input  logic [IDX_W-1:0]       cfg_n_pulses,
  input  logic [IDX_W-1:0]       cfg_n_samples,
  input  logic [IDX_W-1:0]       cfg_start_index,
  input  logic [IDX_W-1:0]       cfg_end_index,
  input  logic                   cfg_update,
  pulse_int_sched_if.master      acc,
  output logic [IDX_W-1:0]       sample_idx,
  output logic [IDX_W-1:0]       pulse_idx,
  output logic                   frame_done,
  output logic [FRAME_CNT_W-1:0] frame_count,
  output logic                   busy,
  output logic                   err_late_trig,
  output logic                   err_cfg
);

  state_t state;
  logic   trig_q;
  logic   trig_edge;
  cfg_t   cfg_in;
  cfg_t   shadow;
  logic   in_ok;
  logic   err_clr;
  logic   idle_req;
  logic   capture;
  logic   last_sample;
  logic   last_pulse;
  logic   frame_end;

  assign trig_edge   = trigger & ~trig_q;
  assign capture     = (state == ST_CAPTURE);
  assign last_sample = (sample_idx == shadow.n_samples - IDX_W'(1));
  assign last_pulse  = (pulse_idx == shadow.n_pulses - IDX_W'(1));
  assign idle_req    = (state == ST_IDLE) & enable & ~abort;
  assign frame_end   = capture & s_axis_tvalid & last_sample & last_pulse & ~abort;
  assign busy        = (state != ST_IDLE);

  assign cfg_in = '{n_pulses:  cfg_n_pulses,
                    n_samples: cfg_n_samples,
                    start_idx: cfg_start_index,
                    end_idx:   cfg_end_index};

  pulse_int_cfg_shadow u_cfg_shadow (
    .aclk       (aclk),
    .aresetn    (aresetn),
    .cfg_in     (cfg_in),
    .cfg_update (cfg_update),
    .idle_req   (idle_req),
    .frame_end  (frame_end),
    .shadow     (shadow),
    .in_ok      (in_ok),
    .err_cfg    (err_cfg),
    .err_clr    (err_clr)
  );

  // Strobes follow the sample in the same cycle.
  assign acc.acc_wr_en  = s_axis_tvalid & capture;
  assign acc.acc_bypass = acc.acc_wr_en & (pulse_idx == '0);
  assign acc.acc_rd_en  = acc.acc_wr_en & (pulse_idx != '0);
  assign acc.out_valid  = acc.acc_rd_en & last_pulse &
                          (sample_idx >= shadow.start_idx) &
                          (sample_idx <= shadow.end_idx);

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state         <= ST_IDLE;
      trig_q        <= 1'b0;
      sample_idx    <= '0;
      pulse_idx     <= '0;
      frame_done    <= 1'b0;
      frame_count   <= '0;
      err_late_trig <= 1'b0;
    end else begin
      trig_q     <= trigger;
      frame_done <= 1'b0;
      if (err_clr)
        err_late_trig <= 1'b0;

      if (abort) begin
        state      <= ST_IDLE;
        sample_idx <= '0;
        pulse_idx  <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (enable && in_ok)
              state <= ST_ARMED;
          end
          ST_ARMED: begin
            // Nothing has been captured yet, so a dropped enable just disarms.
            if (trig_edge) begin
              state      <= ST_CAPTURE;
              sample_idx <= '0;
              pulse_idx  <= '0;
            end else if (!enable) begin
              state <= ST_IDLE;
            end
          end
          ST_CAPTURE: begin
            // A late edge is flagged but does not restart the pulse.
            if (trig_edge)
              err_late_trig <= 1'b1;
            if (s_axis_tvalid) begin
              if (last_sample) begin
                sample_idx <= '0;
                if (last_pulse) begin
                  pulse_idx   <= '0;
                  frame_done  <= 1'b1;
                  frame_count <= frame_count + FRAME_CNT_W'(1);
                  state       <= enable ? ST_GAP : ST_IDLE;
                end else begin
                  pulse_idx <= pulse_idx + IDX_W'(1);
                  state     <= ST_GAP;
                end
              end else begin
                sample_idx <= sample_idx + IDX_W'(1);
              end
            end
          end
          ST_GAP: begin
            // Mid-frame the gap waits for the next pulse regardless of enable.
            if (trig_edge)
              state <= ST_CAPTURE;
            else if (!enable && pulse_idx == '0)
              state <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/pulse_int_sched.md
Name: pulse_int_sched

Overview:
Sequencer for the pulse-integration datapath. Aligns ADC sample streams to an external pulse trigger and counts samples within each pulse and pulses within each integration frame. Drives the accumulator FIFO write, read and bypass strobes, and the gated output valid. Shadows runtime configuration so that changes only take effect on frame boundaries.

Parameters:
IDX_W, 16, width of sample/pulse index counters and config fields
FRAME_CNT_W, 32, width of completed-frame counter

Ports:
aclk  in  1  clock
aresetn  in  1  reset
enable  in  1  run request; level
abort  in  1  single-cycle strobe; discard current frame, go IDLE
trigger  in  1  pulse-start marker from timing unit; rising edge used
s_axis_tvalid  in  1  ADC sample valid (sample stream, always accepted)
cfg_n_pulses  in  IDX_W  pulses per frame
cfg_n_samples  in  IDX_W  samples per pulse
cfg_start_index  in  IDX_W  first output sample within pulse (inclusive)
cfg_end_index  in  IDX_W  last output sample within pulse (inclusive)
cfg_update  in  1  strobe; request new config
acc_wr_en  out  1  write summed/raw sample into accumulator FIFO
acc_rd_en  out  1  pop previous partial sum from FIFO
acc_bypass  out  1  first pulse of frame: write raw sample, no add
out_valid  out  1  final-pulse sample inside window; emit FIFO sum downstream
sample_idx  out  IDX_W  index of next sample within pulse
pulse_idx  out  IDX_W  index of current pulse within frame
frame_done  out  1  one-cycle pulse on last sample of frame
frame_count  out  FRAME_CNT_W  completed frames, wraps
busy  out  1  state != IDLE
err_late_trig  out  1  sticky: trigger edge while CAPTURE
err_cfg  out  1  sticky: config rejected

Behaviour:
- Interface: reset aresetn, synchronous, active-low; clock aclk. All outputs 0 in reset; state IDLE; shadow config 0; update_pending 0.
- Trigger edge: trig_q registered; edge = trigger & ~trig_q.
- Config: cfg_update sets update_pending. Shadow loads from cfg_* on IDLE->ARMED and at frame_done if update_pending (then clears). Valid config: n_pulses>=1, n_samples>=1, start<=end<n_samples. Invalid at IDLE exit -> stay IDLE, set err_cfg. Invalid at frame boundary -> keep old shadow, set err_cfg. err_* clear only on reset, or on a cfg_update that carries valid config.
- States:
  IDLE: enable=1 -> ARMED (load config).
  ARMED: edge -> CAPTURE, sample_idx=0, pulse_idx=0. The sample in the edge cycle is ignored.
  CAPTURE: each tvalid cycle advances sample_idx. On the tvalid with sample_idx==n_samples-1:
  - If not the last pulse: pulse_idx++, sample_idx=0 -> GAP.
  - If pulse_idx==n_pulses-1: frame_done=1 (registered, high the following cycle), frame_count++, pulse_idx=0, sample_idx=0. Next state is GAP if enable else IDLE.
  GAP: edge -> CAPTURE; enable=0 while pulse_idx==0 -> IDLE.
- Edge in CAPTURE: ignored, err_late_trig=1, counting continues.
- enable dropped mid-frame: frame completes, then IDLE.
- abort: highest priority after reset. Next state IDLE; indices 0. No frame_done; frame_count unchanged.
- Strobes (combinational from registered state/indices and s_axis_tvalid; zero latency to the sample):
  - acc_wr_en = tvalid & CAPTURE
  - acc_bypass = acc_wr_en & (pulse_idx==0)
  - acc_rd_en = acc_wr_en & (pulse_idx!=0)
  - out_valid = acc_rd_en & (pulse_idx==n_pulses-1) & (start<=sample_idx<=end)
- n_pulses==1: no rd, out_valid never asserts (no integration output); documented, matches FIFO semantics.
- Indices compare unsigned at IDX_W; frame_count wraps modulo 2^FRAME_CNT_W.

Decomposition:
- pulse_int_pkg: state enum (IDLE, ARMED, CAPTURE, GAP), IDX_W default, config struct (n_pulses, n_samples, start, end), cfg_valid function.
- Sub-module pulse_int_cfg_shadow: pending flag, validation, shadow registers, err_cfg; the FSM/counters stay in the top level.

Test Plan:
- Config n_pulses=3, n_samples=8, window 2..5, three triggers, continuous tvalid -> bypass on 8 samples of pulse 0; rd on 16 samples; out_valid exactly 4 cycles (idx 2..5) of pulse 2; frame_done once; frame_count=1.
- tvalid toggling 50% during CAPTURE -> indices advance only on valid cycles; strobe counts are identical to the continuous case.
- Trigger at sample_idx=4 of pulse 1 -> err_late_trig=1; pulse still ends after 8 samples; frame completes normally.
- cfg_update with n_samples=4 mid-frame -> current frame uses 8; next frame 4 samples/pulse. cfg_update with start=5, end=2 -> err_cfg=1, old config retained.
- abort at pulse 1 sample 3 -> IDLE next cycle, busy=0, no frame_done, frame_count unchanged. Re-enable -> clean frame.
- aresetn low mid-CAPTURE for 1 cycle -> all outputs 0, frame_count=0, state IDLE.
